fp_norm_sched: RTL and testbench

Round-robin scheduler that shares one combinational `fp_norm` normalizer between `N_REQ` arithmetic requesters in the rendering pipeline. Each requester hands over an unnormalized {sign, exp5, frac2.15} operand on a valid/ready handshake. The block registers the operand, drives the shared normalizer and registers the 22-bit result. It returns the result on a single valid/ready result port, tagged with the requester ID. It also keeps a saturating count of underflow flushes for debug.

---
 rtl/fp_norm_sched.sv | 130 +++++++++++++
 tb/tb_fp_norm_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_sched.sv
// Round-robin scheduler sharing one combinational fp_norm normalizer between
// N_REQ requesters: two-stage pipeline (operand register, result register).
module fp_norm_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [N_REQ-1:0]     i_req_s,
  input  logic [5*N_REQ-1:0]   i_req_e,
  input  logic [17*N_REQ-1:0]  i_req_f,
  output logic [N_REQ-1:0]     o_req_ready,
  output logic                 o_norm_s,
  output logic [4:0]           o_norm_e,
  output logic [16:0]          o_norm_f,
  input  logic [21:0]          i_norm_b,
  output logic                 o_res_valid,
  output logic [ID_W-1:0]      o_res_id,
  output logic [21:0]          o_res_b,
  input  logic                 i_res_ready,
  input  logic                 i_cnt_clr,
  output logic [15:0]          o_uf_cnt,
  output logic [ID_W-1:0]      o_dbg_ptr
);

  // Handshake: a transfer happens on a cycle where valid & ready are both high
  // at the rising edge; a producer holds valid and data stable until then.

  logic [ID_W-1:0]  p;
  logic             s1_vld;
  logic [ID_W-1:0]  s1_id;
  logic             s1_s;
  logic [4:0]       s1_e;
  logic [16:0]      s1_f;
  logic             s2_vld;
  logic [ID_W-1:0]  s2_id;
  logic [21:0]      s2_b;
  logic [15:0]      uf_cnt;

  logic             found;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  cand;
  logic [31:0]      j;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  p_nxt;
  logic             s2_can_load;
  logic             s1_adv;
  logic             s1_can_load;
  logic             accept;
  logic             uf_hit;

  // First valid requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    j        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j    = (32'(p) + 32'(i)) % 32'(N_REQ);
      cand = ID_W'(j);
      if (!found && i_req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  assign grant       = found ? (N_REQ'(1) << grant_id) : '0;
  assign p_nxt       = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

  assign s2_can_load = !s2_vld || i_res_ready;
  assign s1_adv      = s1_vld && s2_can_load;
  assign s1_can_load = !s1_vld || s1_adv;
  assign accept      = found && s1_can_load;
  assign o_req_ready = grant & {N_REQ{s1_can_load}};

  // A nonzero fraction that comes back with a zero exponent was flushed.
  assign uf_hit      = s1_adv && (s1_f != '0) && (i_norm_b[20:16] == 5'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p      <= '0;
      s1_vld <= 1'b0;
      s1_id  <= '0;
      s1_s   <= 1'b0;
      s1_e   <= '0;
      s1_f   <= '0;
      s2_vld <= 1'b0;
      s2_id  <= '0;
      s2_b   <= '0;
      uf_cnt <= '0;
    end else begin
      if (accept) begin
        p      <= p_nxt;
        s1_vld <= 1'b1;
        s1_id  <= grant_id;
        s1_s   <= i_req_s[grant_id];
        s1_e   <= i_req_e[32'(grant_id)*5 +: 5];
        s1_f   <= i_req_f[32'(grant_id)*17 +: 17];
      end else begin
        s1_vld <= s1_vld && !s1_adv;
      end

      if (s1_adv) begin
        s2_vld <= 1'b1;
        s2_id  <= s1_id;
        s2_b   <= i_norm_b;
      end else if (s2_vld && i_res_ready) begin
        s2_vld <= 1'b0;
      end

      if (i_cnt_clr) begin
        uf_cnt <= '0;
      end else if (uf_hit && (uf_cnt != 16'hFFFF)) begin
        uf_cnt <= uf_cnt + 16'd1;
      end
    end
  end

  assign o_norm_s    = s1_s;
  assign o_norm_e    = s1_e;
  assign o_norm_f    = s1_f;
  assign o_res_valid = s2_vld;
  assign o_res_id    = s2_id;
  assign o_res_b     = s2_b;
  assign o_uf_cnt    = uf_cnt;
  assign o_dbg_ptr   = p;

endmodule

// File: tb/tb_fp_norm_sched.sv
// Bench for fp_norm_sched: provides a behavioural normalizer and checks the
// result stream against a queue of expected {id, result} words.
module tb_fp_norm_sched;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N_REQ-1:0]     req_valid = '0;
  logic [N_REQ-1:0]     req_s = '0;
  logic [5*N_REQ-1:0]   req_e = '0;
  logic [17*N_REQ-1:0]  req_f = '0;
  logic [N_REQ-1:0]     req_ready;
  logic                 norm_s;
  logic [4:0]           norm_e;
  logic [16:0]          norm_f;
  logic [21:0]          norm_b;
  logic                 res_valid;
  logic [ID_W-1:0]      res_id;
  logic [21:0]          res_b;
  logic                 res_ready = 1'b1;
  logic                 cnt_clr = 1'b0;
  logic [15:0]          uf_cnt;
  logic [ID_W-1:0]      dbg_ptr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [ID_W+21:0] exp_q[$];

  fp_norm_sched #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_s(req_s), .i_req_e(req_e), .i_req_f(req_f),
    .o_req_ready(req_ready),
    .o_norm_s(norm_s), .o_norm_e(norm_e), .o_norm_f(norm_f), .i_norm_b(norm_b),
    .o_res_valid(res_valid), .o_res_id(res_id), .o_res_b(res_b),
    .i_res_ready(res_ready), .i_cnt_clr(cnt_clr), .o_uf_cnt(uf_cnt),
    .o_dbg_ptr(dbg_ptr)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference normalizer: f2.15 in, f1.15 out, flush to zero on exponent underflow.
  function automatic logic [21:0] norm_model(logic s, logic [4:0] e, logic [16:0] f);
    int ne;
    logic [16:0] ff;
    if (f == '0) return 22'h0;
    ne = int'(e);
    if (f[16]) begin
      ne = ne + 1;
      if (ne > 31) ne = 31;
      return {s, 5'(ne), f[16:1]};
    end
    ff = f;
    while (!ff[15]) begin
      ff = ff << 1;
      ne = ne - 1;
    end
    if (ne <= 0) return 22'h0;
    return {s, 5'(ne), ff[15:0]};
  endfunction

  assign norm_b = norm_model(norm_s, norm_e, norm_f);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on result transfer.
  always @(negedge clk) begin
    logic [ID_W+21:0] e;
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("res_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_id", 32'(res_id), 32'(e[ID_W+21:22]));
        check("res_b", 32'(res_b), 32'(e[21:0]));
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (req_valid[k] && req_ready[k])
        exp_q.push_back({ID_W'(k), norm_model(req_s[k], req_e[k*5 +: 5], req_f[k*17 +: 17])});
    end
    if (rst) exp_q.delete();
  end

  // Driver tasks
  task automatic set_op(input int k, input logic s, input logic [4:0] e, input logic [16:0] f);
    req_s[k]         = s;
    req_e[k*5 +: 5]  = e;
    req_f[k*17 +: 17] = f;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_n(input int k, input logic s, input logic [4:0] e, input logic [16:0] f,
                        input int n);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    set_op(k, s, e, f);
    req_valid[k] = 1'b1;
    while (got < n && cyc < n * 4 + 100) begin
      @(negedge clk);
      if (req_ready[k]) got++;
      @(posedge clk);
      #1;
      cyc++;
    end
    req_valid[k] = 1'b0;
    check("send_count", 32'(got), 32'(n));
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || res_valid) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_timeout", 32'(cyc >= 100), 32'd0);
  endtask

  initial begin
    int acc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_res_b", 32'(res_b), 32'd0);
    check("rst_uf_cnt", 32'(uf_cnt), 32'd0);
    check("rst_ptr", 32'(dbg_ptr), 32'd0);
    @(posedge clk);
    #1;

    // Single request, carry case
    set_op(2, 1'b0, 5'h10, 17'h10000);
    req_valid[2] = 1'b1;
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_id", 32'(res_id), 32'd2);
    check("single_b", 32'(res_b), 32'h118000);
    check("single_ptr", 32'(dbg_ptr), 32'd3);
    drain();

    // Round robin, all requesters valid
    do_reset();
    for (int k = 0; k < N_REQ; k++) set_op(k, 1'b0, 5'h10, 17'h08000);
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(1) << (i % N_REQ));
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    drain();

    // Backpressure: two operands in flight, then stall
    res_ready = 1'b0;
    set_op(0, 1'b0, 5'h10, 17'h0C000);
    req_valid[0] = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req_ready[0]) acc++;
      if (i >= 2) begin
        check("bp_ready", 32'(req_ready), 32'd0);
        check("bp_hold", 32'(res_b), 32'h10C000);
      end
      @(posedge clk);
      #1;
    end
    check("bp_accepts", 32'(acc), 32'd2);
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_resume", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    drain();

    // Underflow counter
    send_n(1, 1'b0, 5'h01, 17'h00100, 1);
    drain();
    check("uf_one", 32'(uf_cnt), 32'd1);
    send_n(1, 1'b0, 5'h01, 17'h00000, 1);
    drain();
    check("uf_zero_frac", 32'(uf_cnt), 32'd1);
    send_n(0, 1'b0, 5'h01, 17'h00100, 65534);
    drain();
    check("uf_full", 32'(uf_cnt), 32'hFFFF);
    send_n(0, 1'b0, 5'h01, 17'h00100, 1);
    drain();
    check("uf_saturate", 32'(uf_cnt), 32'hFFFF);
    set_op(0, 1'b0, 5'h01, 17'h00100);
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    check("uf_clr_prio", 32'(uf_cnt), 32'd0);
    drain();

    // Reset mid-flight
    res_ready = 1'b0;
    send_n(2, 1'b0, 5'h10, 17'h08000, 2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 res_ready = 1'b1;
    for (int k = 0; k < N_REQ; k++) set_op(k, 1'b1, 5'h12, 17'h04000);
    req_valid = '1;
    @(negedge clk);
    check("mid_rst_first", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1 req_valid = '0;
    drain();

    // Valid withdrawn while stalled
    res_ready = 1'b0;
    send_n(0, 1'b0, 5'h10, 17'h08000, 2);
    set_op(1, 1'b0, 5'h08, 17'h18000);
    set_op(3, 1'b1, 5'h09, 17'h00300);
    req_valid = 4'b1010;
    @(negedge clk);
    check("wd_stall_ready", 32'(req_ready), 32'd0);
    check("wd_stall_ptr", 32'(dbg_ptr), 32'd1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    check("wd_ptr_hold", 32'(dbg_ptr), 32'd1);
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    check("wd_grant3", 32'(req_ready), 32'b1000);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("wd_ptr_next", 32'(dbg_ptr), 32'd0);
    drain();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
